// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that time-shares one combinational 32-bit ALU among N_REQ requesters.
// One operation in flight: IDLE grants and latches operands, EXEC samples the ALU, RESP holds the result.
module alu_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [4*N_REQ-1:0]    req_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_op,
  input  logic [31:0]           alu_y,
  input  logic [3:0]            alu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_y,
  output logic [3:0]            rsp_flags,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is only ever offered in IDLE, to the single round-robin winner.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_CLEAR = 4'b0011;

  state_t            state_q;
  logic [ID_W-1:0]   last_grant_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [3:0]        op_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [31:0]       rsp_y_q;
  logic [3:0]        rsp_flags_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand_idx;

  // Scan starts one past the previous winner so every waiting requester is reached within N_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_y_q      <= '0;
      rsp_flags_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            a_q          <= req_a[32*int'(grant_idx) +: 32];
            b_q          <= req_b[32*int'(grant_idx) +: 32];
            op_q         <= req_op[4*int'(grant_idx) +: 4];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_y_q     <= alu_y;
          rsp_flags_q <= alu_flags;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The shared ALU sees a clear op with zero operands whenever it is not executing for us.
  assign alu_a       = (state_q == S_EXEC) ? a_q  : 32'd0;
  assign alu_b       = (state_q == S_EXEC) ? b_q  : 32'd0;
  assign alu_op      = (state_q == S_EXEC) ? op_q : OP_CLEAR;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_flags   = rsp_flags_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
